conv_window_ctrl: RTL

Sequencer for the 16-bit pixel register chain and line buffers that build KxK convolution windows over an MNIST frame.
- Accepts a raster-order pixel stream through a valid/ready handshake.
- Issues shift enables and line-buffer write addresses to the register datapath.
- Flags each cycle on which the register chain holds a complete window, and supports downstream backpressure.
- Sits between the input pixel source and the convolution MAC array.

---
 rtl/conv_window_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl: sequencer for the KxK window register chain and line buffers.
// Accepts a raster-order pixel stream, drives shift enables and line-buffer
// addresses, and flags complete windows with downstream backpressure.
// Optional build macro CONV_CTRL_STATS_EN adds stall_cnt / win_cnt outputs.
module conv_window_ctrl #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int K     = 3,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             shift_en,
  output logic [CNT_W-1:0] lb_wr_addr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_row,
  output logic [CNT_W-1:0] out_col,
  output logic             frame_done
`ifdef CONV_CTRL_STATS_EN
  ,
  output logic [15:0]      stall_cnt,
  output logic [15:0]      win_cnt
`endif
);

  localparam logic [CNT_W-1:0] LP_KM1   = CNT_W'(K - 1);
  localparam logic [CNT_W-1:0] LP_LCOL  = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] LP_LROW  = CNT_W'(IMG_H - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_row;
  logic [CNT_W-1:0] r_col;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_out_row;
  logic [CNT_W-1:0] r_out_col;

  logic w_in_ready;
  logic w_accept;
  logic w_last_col;
  logic w_last_pix;
  logic w_win;
  logic w_start_frame;

  assign w_in_ready    = (r_state == S_RUN) && (!r_out_valid || out_ready);
  assign w_accept      = in_valid && w_in_ready;
  assign w_last_col    = (r_col == LP_LCOL);
  assign w_last_pix    = w_last_col && (r_row == LP_LROW);
  assign w_win         = w_accept && (r_row >= LP_KM1) && (r_col >= LP_KM1);
  assign w_start_frame = (r_state == S_IDLE) && start;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_accept && w_last_pix) w_state_nxt = S_DRAIN;
      S_DRAIN: if (!r_out_valid || out_ready) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Raster row/column counters; wrap to zero after the last pixel
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_start_frame) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_accept) begin
      if (w_last_col) begin
        r_col <= '0;
        r_row <= w_last_pix ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Window flag and top-left coordinates; a new window overrides a consume
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_row   <= '0;
      r_out_col   <= '0;
    end else if (w_win) begin
      r_out_valid <= 1'b1;
      r_out_row   <= r_row - LP_KM1;
      r_out_col   <= r_col - LP_KM1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef CONV_CTRL_STATS_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_win_cnt;
  logic        w_active;

  assign w_active = (r_state == S_RUN) || (r_state == S_DRAIN);

  // Saturating stall and hand-off counters, cleared at frame start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_win_cnt   <= '0;
    end else if (w_start_frame) begin
      r_stall_cnt <= '0;
      r_win_cnt   <= '0;
    end else begin
      if (w_active && r_out_valid && !out_ready && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (r_out_valid && out_ready && (r_win_cnt != '1))
        r_win_cnt <= r_win_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign win_cnt   = r_win_cnt;
`endif

  assign busy       = (r_state != S_IDLE);
  assign in_ready   = w_in_ready;
  assign shift_en   = w_accept;
  assign lb_wr_addr = r_col;
  assign out_valid  = r_out_valid;
  assign out_row    = r_out_row;
  assign out_col    = r_out_col;
  assign frame_done = (r_state == S_DONE);

endmodule
